// File: rtl/esfa_pkg.sv
// Shared types and helpers for the ESFA array-level allocation logic.
package esfa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } alloc_state_t;

  localparam int HANDLE_W = 8;

  // Increment with an explicit compare so non-power-of-two limits wrap correctly.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned limit);
    return (idx >= limit - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cell_alloc_controller_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after rr_ptr, circularly.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [RW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [RW-1:0]      gnt_idx
);

  always_comb begin
    logic found;
    int   idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = RW'(idx);
      end
    end
  end

endmodule

// File: rtl/cell_alloc_controller.sv
// Shared next-fit cell allocator: arbitrates requesters, scans one cell per cycle, claims first free.
module cell_alloc_controller
  import esfa_pkg::*;
#(
  parameter int NUM_CELLS = 16,
  parameter int NUM_REQ   = 2,
  parameter int HANDLE_W  = esfa_pkg::HANDLE_W,
  localparam int IDX_W    = $clog2(NUM_CELLS),
  localparam int RW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  done,
  output logic                rsp_ok,
  output logic [HANDLE_W-1:0] rsp_handle,
  output logic [IDX_W-1:0]    cell_idx,
  input  logic                cell_avail,
  input  logic [HANDLE_W-1:0] cell_handle,
  output logic                claim_valid,
  output logic [IDX_W-1:0]    claim_idx,
  input  logic                cell_freed,
  output logic                busy,
  output logic                full
);

  alloc_state_t        state_q;
  logic [NUM_REQ-1:0]  done_q, owner_oh_q, gnt;
  logic [RW-1:0]       rr_ptr_q, owner_q, gnt_idx;
  logic [IDX_W-1:0]    nf_ptr_q, cell_idx_q, scan_cnt_q, claim_idx_q;
  logic [HANDLE_W-1:0] rsp_handle_q;
  logic                rsp_ok_q, claim_valid_q, busy_q, full_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      done_q        <= '0;
      owner_oh_q    <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      nf_ptr_q      <= '0;
      cell_idx_q    <= '0;
      scan_cnt_q    <= '0;
      claim_idx_q   <= '0;
      rsp_handle_q  <= '0;
      rsp_ok_q      <= 1'b0;
      claim_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      full_q        <= 1'b0;
    end else begin
      // A failing RESP below overrides this, so the RESP result wins on a tie.
      if (cell_freed) full_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q    <= gnt_idx;
            owner_oh_q <= gnt;
            cell_idx_q <= nf_ptr_q;
            scan_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (cell_avail) begin
            rsp_handle_q  <= cell_handle;
            claim_idx_q   <= cell_idx_q;
            rsp_ok_q      <= 1'b1;
            claim_valid_q <= 1'b1;
            done_q        <= owner_oh_q;
            state_q       <= RESP;
          end else if (scan_cnt_q == IDX_W'(NUM_CELLS - 1)) begin
            rsp_handle_q  <= '0;
            rsp_ok_q      <= 1'b0;
            done_q        <= owner_oh_q;
            state_q       <= RESP;
          end else begin
            cell_idx_q <= IDX_W'(wrap_inc(32'(cell_idx_q), NUM_CELLS));
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        RESP: begin
          done_q        <= '0;
          claim_valid_q <= 1'b0;
          if (rsp_ok_q) begin
            nf_ptr_q <= IDX_W'(wrap_inc(32'(claim_idx_q), NUM_CELLS));
            full_q   <= 1'b0;
          end else begin
            full_q   <= 1'b1;
          end
          rr_ptr_q <= RW'(wrap_inc(32'(owner_q), NUM_REQ));
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done        = done_q;
  assign rsp_ok      = rsp_ok_q;
  assign rsp_handle  = rsp_handle_q;
  assign cell_idx    = cell_idx_q;
  assign claim_valid = claim_valid_q;
  assign claim_idx   = claim_idx_q;
  assign busy        = busy_q;
  assign full        = full_q;

endmodule

// File: tb/tb_cell_alloc_controller.sv
// Directed bench for cell_alloc_controller: vector table plus multi-cycle corner sequences.
module tb_cell_alloc_controller;

  localparam int NC = 16;
  localparam int NR = 2;
  localparam int HW = 8;
  localparam int IW = 4;

  logic          clk, rst_n;
  logic [NR-1:0] req, done;
  logic          rsp_ok, cell_avail, claim_valid, cell_freed, busy, full;
  logic [HW-1:0] rsp_handle, cell_handle;
  logic [IW-1:0] cell_idx, claim_idx;
  logic [NC-1:0] free_mask;

  int checks = 0;
  int failures = 0;

  cell_alloc_controller #(.NUM_CELLS(NC), .NUM_REQ(NR), .HANDLE_W(HW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .rsp_ok(rsp_ok),
    .rsp_handle(rsp_handle), .cell_idx(cell_idx), .cell_avail(cell_avail),
    .cell_handle(cell_handle), .claim_valid(claim_valid), .claim_idx(claim_idx),
    .cell_freed(cell_freed), .busy(busy), .full(full)
  );

  // Cell array model: handle of cell i is the index repeated in both nibbles.
  assign cell_avail  = free_mask[cell_idx];
  assign cell_handle = {cell_idx, cell_idx};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string         nm;
    logic [NC-1:0] fm;
    logic [NR-1:0] rq;
    logic [NR-1:0] ed;
    logic          eok;
    logic [HW-1:0] eh;
    logic [IW-1:0] ec;
    int            el;
    logic [IW-1:0] es;
    logic          ef;
  } vec_t;

  task automatic do_alloc(input vec_t v);
    int c;
    @(negedge clk);
    free_mask = v.fm;
    req       = v.rq;
    c = 0;
    do begin
      @(posedge clk); c++; #1;
      if (c == 1) chk({v.nm, ".start_idx"}, 32'(cell_idx), 32'(v.es));
    end while (done == '0 && c < 40);
    chk({v.nm, ".latency"}, c, v.el);
    chk({v.nm, ".done"}, 32'(done), 32'(v.ed));
    chk({v.nm, ".rsp_ok"}, 32'(rsp_ok), 32'(v.eok));
    chk({v.nm, ".handle"}, 32'(rsp_handle), 32'(v.eh));
    chk({v.nm, ".claim_valid"}, 32'(claim_valid), 32'(v.eok));
    if (v.eok) chk({v.nm, ".claim_idx"}, 32'(claim_idx), 32'(v.ec));
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    chk({v.nm, ".done_pulse"}, 32'(done), 0);
    chk({v.nm, ".claim_pulse"}, 32'(claim_valid), 0);
    chk({v.nm, ".busy_after"}, 32'(busy), 0);
    chk({v.nm, ".full_after"}, 32'(full), 32'(v.ef));
  endtask

  vec_t vt[9];
  vec_t hv;
  logic [NR-1:0] rr_exp[4];

  initial begin
    int c;
    //              name   free        req    done   ok    hdl    claim lat  start full
    vt[0] = '{"basic",   16'h0008, 2'b01, 2'b01, 1'b1, 8'h33, 4'd3,  5,  4'd0,  1'b0};
    vt[1] = '{"scanwrap",16'h0002, 2'b01, 2'b01, 1'b1, 8'h11, 4'd1,  15, 4'd4,  1'b0};
    vt[2] = '{"fullarr", 16'h0000, 2'b10, 2'b10, 1'b0, 8'h00, 4'd0,  17, 4'd2,  1'b1};
    vt[3] = '{"first_k0",16'h0204, 2'b11, 2'b01, 1'b1, 8'h22, 4'd2,  2,  4'd2,  1'b0};
    vt[4] = '{"rr_req1", 16'h0204, 2'b11, 2'b10, 1'b1, 8'h99, 4'd9,  8,  4'd3,  1'b0};
    vt[5] = '{"top_cell",16'h8000, 2'b10, 2'b10, 1'b1, 8'hFF, 4'd15, 7,  4'd10, 1'b0};
    vt[6] = '{"cell0",   16'h0001, 2'b01, 2'b01, 1'b1, 8'h00, 4'd0,  2,  4'd0,  1'b0};
    vt[7] = '{"to_nf14", 16'h2000, 2'b01, 2'b01, 1'b1, 8'hDD, 4'd13, 14, 4'd1,  1'b0};
    vt[8] = '{"nf_wrap", 16'h0002, 2'b10, 2'b10, 1'b1, 8'h11, 4'd1,  5,  4'd14, 1'b0};

    rst_n = 1'b0; req = '0; cell_freed = 1'b0; free_mask = '0;
    #1;
    chk("rst.done", 32'(done), 0);
    chk("rst.rsp_ok", 32'(rsp_ok), 0);
    chk("rst.handle", 32'(rsp_handle), 0);
    chk("rst.claim_valid", 32'(claim_valid), 0);
    chk("rst.claim_idx", 32'(claim_idx), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.full", 32'(full), 0);
    chk("rst.cell_idx", 32'(cell_idx), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) do_alloc(vt[i]);

    // Full array from requester 0, then a free pulse clears the sticky flag.
    hv = '{"full_a", 16'h0000, 2'b01, 2'b01, 1'b0, 8'h00, 4'd0, 17, 4'd2, 1'b1};
    do_alloc(hv);
    @(negedge clk); cell_freed = 1'b1;
    @(negedge clk); cell_freed = 1'b0;
    chk("freed.full", 32'(full), 0);

    // Free pulse coinciding with a failing RESP: the failure must stick.
    @(negedge clk); free_mask = '0; req = 2'b10;
    c = 0;
    do begin @(posedge clk); c++; #1; end while (done == '0 && c < 40);
    chk("tie.latency", c, 17);
    chk("tie.done", 32'(done), 32'(2'b10));
    cell_freed = 1'b1;
    @(negedge clk); req = '0;
    @(posedge clk); #1; cell_freed = 1'b0;
    chk("tie.full", 32'(full), 1);

    // Both requesters held continuously: grants must alternate.
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    @(negedge clk); free_mask = '1; req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      c = 0;
      do begin @(posedge clk); c++; #1; end while (done == '0 && c < 40);
      chk($sformatf("rr.grant%0d", g), 32'(done), 32'(rr_exp[g]));
      chk($sformatf("rr.lat%0d", g), c, (g == 0) ? 2 : 3);
    end
    @(negedge clk); req = '0;
    @(posedge clk); #1;
    chk("rr.full_cleared", 32'(full), 0);

    // Reset in the middle of a scan.
    @(negedge clk); free_mask = '0; req = 2'b01;
    c = 0;
    do begin @(posedge clk); c++; #1; end while (!(busy && cell_idx == 4'd5) && c < 40);
    chk("mid.reached_idx5", 32'(cell_idx), 5);
    rst_n = 1'b0; req = '0;
    #1;
    chk("mid.busy", 32'(busy), 0);
    chk("mid.cell_idx", 32'(cell_idx), 0);
    chk("mid.done", 32'(done), 0);
    chk("mid.claim_valid", 32'(claim_valid), 0);
    @(negedge clk); rst_n = 1'b1;
    c = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done != '0 || claim_valid) c++;
    end
    chk("mid.no_late_done", c, 0);
    hv = '{"post_rst", 16'h0080, 2'b01, 2'b01, 1'b1, 8'h77, 4'd7, 9, 4'd0, 1'b0};
    do_alloc(hv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cell_alloc_controller.md
Name: cell_alloc_controller

Overview:
- Sequences the per-cell "mark available" evaluation across the ESFA cell array.
- Shares one allocation engine between several requesters using round-robin arbitration.
- Scans cells one per cycle with a next-fit pointer, claims the first free cell and returns its handle.
- Sits between the array-level command logic and the cell array's available/handle result bus.

Parameters:
- NUM_CELLS, 16: number of cells in the array, any value ≥ 2.
- NUM_REQ, 2: number of requesters, ≥ 1.
- HANDLE_W, 8: width of a cell handle.
- IDX_W, $clog2(NUM_CELLS): width of a cell index (derived, not overridden).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester level request; held until its done bit.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester.
- rsp_ok  out  1  valid with done: 1 = cell allocated, 0 = array full.
- rsp_handle  out  HANDLE_W  valid with done: allocated handle, 0 on failure.
- cell_idx  out  IDX_W  index of the cell currently presented to the array.
- cell_avail  in  1  combinational result for cell_idx, same cycle (1 = eltDef clear).
- cell_handle  in  HANDLE_W  combinational handle of cell cell_idx.
- claim_valid  out  1  one-cycle pulse: set eltDef on cell claim_idx.
- claim_idx  out  IDX_W  cell to claim; valid with claim_valid.
- cell_freed  in  1  pulse from the free path; clears full.
- busy  out  1  high in any state other than IDLE.
- full  out  1  sticky: the last scan found no free cell.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; done, rsp_ok, rsp_handle, claim_valid, claim_idx, busy, full all 0. Internal pointers: rr_ptr=0, nf_ptr=0, cell_idx=0, scan_cnt=0. Reset mid-scan abandons the request: no claim_valid and no done are issued.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - If any req is set, grant the first set bit at or after rr_ptr, searching circularly upward. Latch owner.
  - Load cell_idx=nf_ptr and scan_cnt=0, then go to SCAN.
  - With no req, stay in IDLE; cell_idx holds its value.
- SCAN, one cell per cycle:
  - If cell_avail=1: latch cell_handle and cell_idx into rsp_handle and claim_idx, set rsp_ok=1, go to RESP.
  - Else if scan_cnt==NUM_CELLS-1: set rsp_ok=0, rsp_handle=0, go to RESP.
  - Else: cell_idx advances by 1, wrapping NUM_CELLS-1 → 0 explicitly (non-power-of-two safe), and scan_cnt increments.
- RESP, exactly one cycle:
  - done[owner]=1. claim_valid=rsp_ok in the same cycle.
  - On success: nf_ptr=claim_idx+1 with wrap, and full is cleared.
  - On failure: full=1 and nf_ptr is unchanged.
  - rr_ptr=owner+1, wrapping at NUM_REQ. Return to IDLE.
- Latency: request seen in IDLE at cycle 0. A hit on the k-th examined cell (k=0..NUM_CELLS-1) gives done at cycle 2+k. A full array gives done at cycle 1+NUM_CELLS.
- Handshake:
  - Requesters are registered and drop req the cycle after done.
  - req still high in IDLE after done counts as a new request.
  - A req dropped before done is ignored. The scan completes and the claim still occurs, with done pulsed regardless.
- cell_freed: clears full in any state. If it coincides with a RESP failure, the RESP failure wins and full=1.
- Requests arriving while busy wait. Arbitration happens only in IDLE.
- rsp_handle and rsp_ok hold their values until the next RESP. They are qualified only by done.

Decomposition:
- Shared package esfa_pkg:
  - alloc_state_t enum {IDLE, SCAN, RESP}
  - localparam HANDLE_W=8
  - function wrap_inc(idx, limit)
- Sub-module rr_arbiter (NUM_REQ): inputs req and rr_ptr, outputs one-hot grant and its index. Purely combinational; rr_ptr is owned by the controller.

Test Plan:
- Basic allocation: NUM_CELLS=16, cells 0–2 defined, 3 free with handle 8'h33, req[0] at cycle 0 → cell_idx 0,1,2,3 on cycles 1–4; done[0], rsp_ok=1, rsp_handle=8'h33, claim_valid with claim_idx=3 at cycle 5; nf_ptr=4.
- Next-fit wrap: nf_ptr=14, only cell 1 free → cell_idx sequence 14,15,0,1; claim_idx=1, done at cycle 5; nf_ptr becomes 2.
- Full array: no free cells, req[1] → 16 scan cycles, done[1] at cycle 17, rsp_ok=0, rsp_handle=0, no claim_valid, full=1. A later cell_freed pulse → full=0.
- Round-robin fairness: req=2'b11 held continuously (each re-asserted after done) → grants alternate 0,1,0,1; no requester is served twice in a row.
- Reset mid-scan: rst_n low during SCAN at cell_idx=5 → same cycle, all outputs 0 and state IDLE; no claim_valid or done follows. After release, a new request restarts from cell_idx=0.
- Simultaneous cell_freed and failing RESP → full=1 at the end of the cycle.
